// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART core: parity modes, FSM states
// and the baud divisor helper.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_t;

   // Rounded clocks per oversample tick.
   function automatic int unsigned baud_div(input int unsigned clk_hz,
                                            input int unsigned bit_rate,
                                            input int unsigned os);
      int unsigned den;
      den = bit_rate * os;
      return (clk_hz + den / 2) / den;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy level.
// A write while full is taken only when a read frees the slot in the same cycle.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_wr,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_wr;
   logic             w_do_rd;

   assign o_level   = r_wr_ptr - r_rd_ptr;
   assign o_empty   = (o_level == '0);
   assign o_full    = (o_level == (AW+1)'(DEPTH));
   assign w_do_rd   = i_rd && !o_empty;
   assign w_do_wr   = i_wr && (!o_full || w_do_rd);
   assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_do_wr)
         r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: tick generator, TX/RX FSMs and two FIFOs.
// RX FIFO entries are {parity_err, frame_err, data}.
module uart_core_param #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned BIT_RATE   = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [DATA_BITS-1:0]            tx_data,
   input  logic                            tx_valid,
   output logic                            tx_ready,
   output logic                            txd,
   input  logic                            rxd,
   output logic [DATA_BITS-1:0]            rx_data,
   output logic                            rx_parity_err,
   output logic                            rx_frame_err,
   output logic                            rx_valid,
   input  logic                            rx_ready,
   output logic                            rx_break,
   output logic                            rx_overrun,
   output logic [$clog2(FIFO_DEPTH):0]     tx_level,
   output logic [$clog2(FIFO_DEPTH):0]     rx_level
);

   import uart_pkg::*;

   localparam int unsigned DIV_RAW = baud_div(CLK_HZ, BIT_RATE, OVERSAMPLE);
   localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned TW      = $clog2(2 * OVERSAMPLE);
   localparam int unsigned BW      = $clog2(DATA_BITS);

   logic [DIV_W-1:0]      r_div_cnt;
   logic                  w_tick;

   assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n || w_tick) r_div_cnt <= '0;
      else                  r_div_cnt <= r_div_cnt + 1'b1;
   end

   tx_state_t             r_tx_state;
   logic                  r_txd;
   logic [TW-1:0]         r_tx_tick;
   logic [BW-1:0]         r_tx_bit;
   logic [DATA_BITS-1:0]  r_tx_shift;
   logic                  r_tx_par;
   logic [DATA_BITS-1:0]  w_tx_head;
   logic                  w_tx_full;
   logic                  w_tx_empty;
   logic                  w_tx_pop;
   logic                  w_tx_par;
   logic                  w_tx_bit_end;
   logic                  w_tx_stop_end;

   assign tx_ready      = !w_tx_full;
   assign txd           = r_txd;
   assign w_tx_par      = (PARITY == PAR_ODD) ? ~^w_tx_head : ^w_tx_head;
   assign w_tx_bit_end  = (r_tx_tick == TW'(OVERSAMPLE - 1));
   assign w_tx_stop_end = (r_tx_tick == TW'(STOP_BITS * OVERSAMPLE - 1));
   // Pop from IDLE or straight out of STOP so consecutive frames have no gap.
   assign w_tx_pop      = w_tick && !w_tx_empty &&
                          ((r_tx_state == TX_IDLE) || (r_tx_state == TX_STOP && w_tx_stop_end));

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr      (tx_valid && !w_tx_full),
      .i_wr_data (tx_data),
      .i_rd      (w_tx_pop),
      .o_rd_data (w_tx_head),
      .o_full    (w_tx_full),
      .o_empty   (w_tx_empty),
      .o_level   (tx_level)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tx_state <= TX_IDLE;
         r_txd      <= 1'b1;
         r_tx_tick  <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_tx_par   <= 1'b0;
      end else if (w_tick) begin
         case (r_tx_state)
            TX_IDLE: begin
               if (!w_tx_empty) begin
                  r_tx_state <= TX_START;
                  r_txd      <= 1'b0;
                  r_tx_tick  <= '0;
                  r_tx_shift <= w_tx_head;
                  r_tx_par   <= w_tx_par;
               end
            end
            TX_START: begin
               if (w_tx_bit_end) begin
                  r_tx_state <= TX_DATA;
                  r_txd      <= r_tx_shift[0];
                  r_tx_tick  <= '0;
                  r_tx_bit   <= '0;
               end else r_tx_tick <= r_tx_tick + 1'b1;
            end
            TX_DATA: begin
               if (w_tx_bit_end) begin
                  r_tx_tick <= '0;
                  if (r_tx_bit == BW'(DATA_BITS - 1)) begin
                     if (PARITY == PAR_NONE) begin
                        r_tx_state <= TX_STOP;
                        r_txd      <= 1'b1;
                     end else begin
                        r_tx_state <= TX_PARITY;
                        r_txd      <= r_tx_par;
                     end
                  end else begin
                     r_tx_bit   <= r_tx_bit + 1'b1;
                     r_tx_shift <= r_tx_shift >> 1;
                     r_txd      <= r_tx_shift[1];
                  end
               end else r_tx_tick <= r_tx_tick + 1'b1;
            end
            TX_PARITY: begin
               if (w_tx_bit_end) begin
                  r_tx_state <= TX_STOP;
                  r_txd      <= 1'b1;
                  r_tx_tick  <= '0;
               end else r_tx_tick <= r_tx_tick + 1'b1;
            end
            TX_STOP: begin
               if (w_tx_stop_end) begin
                  r_tx_tick <= '0;
                  if (!w_tx_empty) begin
                     r_tx_state <= TX_START;
                     r_txd      <= 1'b0;
                     r_tx_shift <= w_tx_head;
                     r_tx_par   <= w_tx_par;
                  end else begin
                     r_tx_state <= TX_IDLE;
                     r_txd      <= 1'b1;
                  end
               end else r_tx_tick <= r_tx_tick + 1'b1;
            end
            default: begin
               r_tx_state <= TX_IDLE;
               r_txd      <= 1'b1;
            end
         endcase
      end
   end

   logic                  r_rx_s1;
   logic                  r_rx_s2;
   logic                  r_rx_s3;
   rx_state_t             r_rx_state;
   logic [TW-1:0]         r_rx_tick;
   logic [BW-1:0]         r_rx_bit;
   logic [DATA_BITS-1:0]  r_rx_shift;
   logic                  r_rx_par_bit;
   logic                  r_rx_push;
   logic [DATA_BITS+1:0]  r_rx_wdata;
   logic                  r_rx_break;
   logic                  r_rx_overrun;
   logic [DATA_BITS+1:0]  w_rx_head;
   logic                  w_rx_full;
   logic                  w_rx_empty;
   logic                  w_rx_pop;
   logic                  w_rx_perr;
   logic                  w_rx_bit_end;

   assign rx_valid      = !w_rx_empty;
   assign w_rx_pop      = rx_ready && !w_rx_empty;
   assign rx_data       = w_rx_head[DATA_BITS-1:0];
   assign rx_frame_err  = w_rx_head[DATA_BITS];
   assign rx_parity_err = w_rx_head[DATA_BITS+1];
   assign rx_break      = r_rx_break;
   assign rx_overrun    = r_rx_overrun;
   assign w_rx_bit_end  = (r_rx_tick == TW'(OVERSAMPLE - 1));
   assign w_rx_perr     = (PARITY == PAR_NONE) ? 1'b0 :
                          (PARITY == PAR_ODD)  ? (r_rx_par_bit != ~^r_rx_shift) :
                                                 (r_rx_par_bit != ^r_rx_shift);

   uart_sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr      (r_rx_push),
      .i_wr_data (r_rx_wdata),
      .i_rd      (w_rx_pop),
      .o_rd_data (w_rx_head),
      .o_full    (w_rx_full),
      .o_empty   (w_rx_empty),
      .o_level   (rx_level)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
         r_rx_s3 <= 1'b1;
      end else begin
         r_rx_s1 <= rxd;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rx_state   <= RX_IDLE;
         r_rx_tick    <= '0;
         r_rx_bit     <= '0;
         r_rx_shift   <= '0;
         r_rx_par_bit <= 1'b0;
         r_rx_push    <= 1'b0;
         r_rx_wdata   <= '0;
         r_rx_break   <= 1'b0;
         r_rx_overrun <= 1'b0;
      end else begin
         r_rx_push    <= 1'b0;
         r_rx_break   <= 1'b0;
         // Drop is decided in the cycle the FIFO sees the push, matching its accept rule.
         r_rx_overrun <= r_rx_push && w_rx_full && !w_rx_pop;
         case (r_rx_state)
            RX_IDLE: begin
               if (r_rx_s3 && !r_rx_s2) begin
                  r_rx_state <= RX_START;
                  r_rx_tick  <= '0;
               end
            end
            RX_START: begin
               if (w_tick) begin
                  if (r_rx_tick == TW'(OVERSAMPLE / 2 - 1)) begin
                     r_rx_tick  <= '0;
                     r_rx_bit   <= '0;
                     r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                  end else r_rx_tick <= r_rx_tick + 1'b1;
               end
            end
            RX_DATA: begin
               if (w_tick) begin
                  if (w_rx_bit_end) begin
                     r_rx_tick  <= '0;
                     r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                     if (r_rx_bit == BW'(DATA_BITS - 1))
                        r_rx_state <= (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
                     else
                        r_rx_bit <= r_rx_bit + 1'b1;
                  end else r_rx_tick <= r_rx_tick + 1'b1;
               end
            end
            RX_PARITY: begin
               if (w_tick) begin
                  if (w_rx_bit_end) begin
                     r_rx_tick    <= '0;
                     r_rx_par_bit <= r_rx_s2;
                     r_rx_state   <= RX_STOP;
                  end else r_rx_tick <= r_rx_tick + 1'b1;
               end
            end
            RX_STOP: begin
               if (w_tick) begin
                  if (w_rx_bit_end) begin
                     r_rx_tick <= '0;
                     if (r_rx_shift == '0 && !r_rx_s2) begin
                        r_rx_break <= 1'b1;
                        r_rx_state <= RX_WAIT_IDLE;
                     end else begin
                        r_rx_push  <= 1'b1;
                        r_rx_wdata <= {w_rx_perr, !r_rx_s2, r_rx_shift};
                        r_rx_state <= RX_IDLE;
                     end
                  end else r_rx_tick <= r_rx_tick + 1'b1;
               end
            end
            RX_WAIT_IDLE: begin
               if (r_rx_s2) r_rx_state <= RX_IDLE;
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed/randomised bench for uart_core_param: an even-parity instance (TX/RX,
// loopback) and an odd-parity instance (RX error flags), checked against a frame model.
module tb_uart_core_param;

   localparam int CLK_HZ   = 16000000;
   localparam int BIT_RATE = 250000;
   localparam int OS       = 16;
   localparam int DIV      = (CLK_HZ + (BIT_RATE * OS) / 2) / (BIT_RATE * OS);
   localparam int BITC     = DIV * OS;
   localparam int FRAMEC   = 11 * BITC;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       loop;
   logic [7:0] tx_data_a, tx_data_b, rx_data_a, rx_data_b;
   logic       tx_valid_a, tx_valid_b, tx_ready_a, tx_ready_b;
   logic       txd_a, txd_b, rxd_a, drv_a, drv_b;
   logic       perr_a, perr_b, ferr_a, ferr_b;
   logic       rxv_a, rxv_b, rxr_a, rxr_b;
   logic       brk_a, brk_b, ovr_a, ovr_b;
   logic [4:0] tx_level_a, tx_level_b, rx_level_a, rx_level_b;

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         brk_cnt = 0;
   int         ovr_cnt = 0;
   int         fall_q[$];
   logic       txd_prev = 1'b1;
   logic [7:0] tx_exp[$];

   always #5 clk = ~clk;

   assign rxd_a = loop ? txd_a : drv_a;

   uart_core_param #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .OVERSAMPLE(OS), .DATA_BITS(8),
                     .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_even (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
      .txd(txd_a), .rxd(rxd_a), .rx_data(rx_data_a), .rx_parity_err(perr_a), .rx_frame_err(ferr_a),
      .rx_valid(rxv_a), .rx_ready(rxr_a), .rx_break(brk_a), .rx_overrun(ovr_a),
      .tx_level(tx_level_a), .rx_level(rx_level_a));

   uart_core_param #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .OVERSAMPLE(OS), .DATA_BITS(8),
                     .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_odd (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
      .txd(txd_b), .rxd(drv_b), .rx_data(rx_data_b), .rx_parity_err(perr_b), .rx_frame_err(ferr_b),
      .rx_valid(rxv_b), .rx_ready(rxr_b), .rx_break(brk_b), .rx_overrun(ovr_b),
      .tx_level(tx_level_b), .rx_level(rx_level_b));

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (brk_a) brk_cnt++;
      if (ovr_a) ovr_cnt++;
      if (txd_prev && !txd_a) fall_q.push_back(cyc);
      txd_prev = txd_a;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Parity bit that makes the total count of ones even (mode 2) or odd (mode 1).
   function automatic logic par_bit(input logic [7:0] d, input int mode);
      int ones = 0;
      for (int i = 0; i < 8; i++) if (d[i]) ones++;
      if (mode == 2) return (ones % 2) == 1;
      return (ones % 2) == 0;
   endfunction

   function automatic logic frame_bit(input logic [7:0] d, input int j);
      if (j == 0) return 1'b0;
      if (j <= 8) return d[j-1];
      if (j == 9) return par_bit(d, 2);
      return 1'b1;
   endfunction

   task automatic check_tx(input int first_idx, input int nframes);
      int t0;
      for (int k = 0; k < 4 * FRAMEC && fall_q.size() <= first_idx; k++) @(negedge clk);
      check("tx_start_seen", 32'(fall_q.size() > first_idx), 1);
      if (fall_q.size() > first_idx) begin
         t0 = fall_q[first_idx];
         for (int f = 0; f < nframes; f++) begin
            for (int j = 0; j < 11; j++) begin
               while (cyc < t0 + f * FRAMEC + BITC / 2 + j * BITC) @(negedge clk);
               check($sformatf("txd_f%0d_b%0d", f, j), 32'(txd_a), 32'(frame_bit(tx_exp[f], j)));
            end
         end
      end
   endtask

   task automatic send_frame(input int sel, input logic [7:0] d, input logic par, input logic stop);
      logic [10:0] bits;
      bits = {stop, par, d, 1'b0};
      for (int j = 0; j < 11; j++) begin
         if (sel == 0) drv_a = bits[j];
         else          drv_b = bits[j];
         repeat (BITC) @(negedge clk);
      end
      drv_a = 1'b1;
      drv_b = 1'b1;
      repeat (BITC) @(negedge clk);
   endtask

   task automatic pop_check(input int sel, input string tag, input logic [7:0] d,
                            input logic pe, input logic fe);
      for (int k = 0; k < 2 * FRAMEC && !(sel == 0 ? rxv_a : rxv_b); k++) @(negedge clk);
      check({tag, "_valid"}, 32'(sel == 0 ? rxv_a : rxv_b), 1);
      check({tag, "_data"},  32'(sel == 0 ? rx_data_a : rx_data_b), 32'(d));
      check({tag, "_perr"},  32'(sel == 0 ? perr_a : perr_b), 32'(pe));
      check({tag, "_ferr"},  32'(sel == 0 ? ferr_a : ferr_b), 32'(fe));
      if (sel == 0) rxr_a = 1'b1;
      else          rxr_b = 1'b1;
      @(negedge clk);
      rxr_a = 1'b0;
      rxr_b = 1'b0;
   endtask

   initial begin
      int         idx;
      int         saved;
      logic [7:0] b;
      logic       good_par, good_stop;

      rst_n = 1'b0; loop = 1'b0; drv_a = 1'b1; drv_b = 1'b1;
      tx_data_a = '0; tx_data_b = '0; tx_valid_a = 1'b0; tx_valid_b = 1'b0;
      rxr_a = 1'b0; rxr_b = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_txd", 32'(txd_a), 1);
      check("rst_tx_ready", 32'(tx_ready_a), 1);
      check("rst_rx_valid", 32'(rxv_a), 0);
      check("rst_break", 32'(brk_a), 0);
      check("rst_overrun", 32'(ovr_a), 0);
      check("rst_tx_level", 32'(tx_level_a), 0);
      check("rst_rx_level", 32'(rx_level_a), 0);
      check("rst_b_ready_txd", 32'({tx_ready_b, txd_b, rxv_b}), 32'h6);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 1: even parity 0xA5 with txd looped back to rxd
      loop = 1'b1;
      tx_exp.delete();
      tx_exp.push_back(8'hA5);
      idx = fall_q.size();
      tx_data_a = 8'hA5; tx_valid_a = 1'b1;
      @(negedge clk);
      tx_valid_a = 1'b0;
      check_tx(idx, 1);
      pop_check(0, "loop", 8'hA5, 1'b0, 1'b0);
      repeat (2 * BITC) @(negedge clk);
      loop = 1'b0;

      // 2: 18 back-to-back random pushes; accepted bytes stream out without gaps
      tx_exp.delete();
      idx = fall_q.size();
      for (int i = 0; i < 18; i++) begin
         b = 8'($urandom);
         tx_data_a = b; tx_valid_a = 1'b1;
         if (tx_ready_a) tx_exp.push_back(b);
         @(negedge clk);
      end
      tx_valid_a = 1'b0;
      check("b2b_accepted", 32'(tx_exp.size()), 17);
      check("b2b_tx_level", 32'(tx_level_a), 16);
      check("b2b_tx_ready", 32'(tx_ready_a), 0);
      check_tx(idx, 17);
      repeat (2 * BITC) @(negedge clk);
      check("b2b_drained", 32'(tx_level_a), 0);

      // 3: odd-parity instance, bad parity then bad stop
      send_frame(1, 8'h3C, 1'b0, 1'b1);
      pop_check(1, "odd_perr", 8'h3C, 1'b1, 1'b0);
      send_frame(1, 8'h3C, par_bit(8'h3C, 1), 1'b0);
      pop_check(1, "odd_ferr", 8'h3C, 1'b0, 1'b1);

      // 4: break, then a normal frame
      saved = brk_cnt;
      drv_a = 1'b0;
      repeat (12 * BITC) @(negedge clk);
      drv_a = 1'b1;
      repeat (2 * BITC) @(negedge clk);
      check("break_pulses", 32'(brk_cnt - saved), 1);
      check("break_rx_level", 32'(rx_level_a), 0);
      send_frame(0, 8'h55, par_bit(8'h55, 2), 1'b1);
      pop_check(0, "after_break", 8'h55, 1'b0, 1'b0);

      // 5: overrun on the 17th frame
      saved = ovr_cnt;
      for (int i = 0; i < 17; i++) send_frame(0, 8'(i), par_bit(8'(i), 2), 1'b1);
      check("ovr_rx_level", 32'(rx_level_a), 16);
      check("ovr_pulses", 32'(ovr_cnt - saved), 1);
      for (int i = 0; i < 16; i++) pop_check(0, $sformatf("ovr_pop%0d", i), 8'(i), 1'b0, 1'b0);
      check("ovr_empty", 32'(rx_level_a), 0);

      // random frames with randomly corrupted parity/stop
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom_range(1, 255));
         good_par = 1'($urandom_range(0, 1));
         good_stop = 1'($urandom_range(0, 1));
         send_frame(0, b, good_par ? par_bit(b, 2) : !par_bit(b, 2), good_stop);
         pop_check(0, $sformatf("rand%0d", i), b, !good_par, !good_stop);
      end

      // 6: short glitch gives nothing
      saved = brk_cnt;
      drv_a = 1'b0;
      repeat (3) @(negedge clk);
      drv_a = 1'b1;
      repeat (2 * BITC) @(negedge clk);
      check("glitch_valid", 32'(rxv_a), 0);
      check("glitch_level", 32'(rx_level_a), 0);
      check("glitch_break", 32'(brk_cnt - saved), 0);

      // reset during a TX frame
      tx_data_a = 8'h00; tx_valid_a = 1'b1;
      repeat (3) @(negedge clk);
      tx_valid_a = 1'b0;
      repeat (300) @(negedge clk);
      check("midtx_txd_low", 32'(txd_a), 0);
      check("midtx_level", 32'(tx_level_a), 2);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_txd", 32'(txd_a), 1);
      check("midrst_tx_level", 32'(tx_level_a), 0);
      check("midrst_tx_ready", 32'(tx_ready_a), 1);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
